// File: rtl/comparador_palavras_sequencial_if.sv
// Operand/result handshake bundle for comparador_palavras_sequencial.
// master = operand source and result consumer; slave = the comparator.
interface comparador_palavras_sequencial_if #(
  parameter int WIDTH     = 3,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [1:0]           mode;
  logic                 out_valid;
  logic                 out_ready;
  logic                 result;
  logic                 eq;
  logic                 lt;
  logic                 gt;
  logic [CNT_WIDTH-1:0] match_count;
  logic                 locked;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result, eq, lt, gt, match_count, locked
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result, eq, lt, gt, match_count, locked
  );
endinterface

// File: rtl/comparador_palavras_sequencial.sv
// Registered WIDTH-bit comparator (EQ/NE/LT/GT) with valid/ready handshake,
// saturating match counter and a consecutive-match lock detector.
module comparador_palavras_sequencial #(
  parameter int WIDTH      = 3,
  parameter int CNT_WIDTH  = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  comparador_palavras_sequencial_if.slave bus_io
);
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    MODE_EQ = 2'b00,
    MODE_NE = 2'b01,
    MODE_LT = 2'b10,
    MODE_GT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_LOCKED
  } state_e;

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic                 result_q, result_d;
  logic                 eq_q, eq_d;
  logic                 lt_q, lt_d;
  logic                 gt_q, gt_d;
  logic [CNT_WIDTH-1:0] match_count_q, match_count_d;
  logic [RUN_W-1:0]     run_q, run_d;
  mode_e                prev_mode_q, prev_mode_d;

  logic  accept;
  logic  eq_c, lt_c, gt_c, result_c;
  mode_e mode_c;

  assign bus_io.in_ready = !out_valid_q || bus_io.out_ready;
  assign accept          = bus_io.in_valid && bus_io.in_ready;

  assign mode_c = mode_e'(bus_io.mode);
  assign eq_c   = (bus_io.a == bus_io.b);
  assign lt_c   = (bus_io.a <  bus_io.b);
  assign gt_c   = (bus_io.a >  bus_io.b);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    result_c      = eq_c;
    out_valid_d   = out_valid_q;
    result_d      = result_q;
    eq_d          = eq_q;
    lt_d          = lt_q;
    gt_d          = gt_q;
    match_count_d = match_count_q;
    run_d         = run_q;
    prev_mode_d   = prev_mode_q;
    state_d       = state_q;

    unique case (mode_c)
      MODE_EQ: result_c = eq_c;
      MODE_NE: result_c = !eq_c;
      MODE_LT: result_c = lt_c;
      MODE_GT: result_c = gt_c;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = result_c;
      eq_d        = eq_c;
      lt_d        = lt_c;
      gt_d        = gt_c;
    end else if (bus_io.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear wins over a simultaneous accept: the result is still presented, just not counted.
    if (clear_i) begin
      match_count_d = '0;
      run_d         = '0;
      prev_mode_d   = MODE_EQ;
    end else if (accept) begin
      prev_mode_d = mode_c;
      if (result_c && (match_count_q != '1)) begin
        match_count_d = match_count_q + CNT_WIDTH'(1);
      end
      // A restart after a mode change equals an increment from zero, so the
      // first transaction after reset/clear needs no special case.
      if (!result_c) begin
        run_d = '0;
      end else if (mode_c != prev_mode_q) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_W'(1);
      end
    end

    if (run_d == '0) begin
      state_d = ST_IDLE;
    end else if (run_d == RUN_MAX) begin
      state_d = ST_LOCKED;
    end else begin
      state_d = ST_TRACK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      result_q      <= 1'b0;
      eq_q          <= 1'b0;
      lt_q          <= 1'b0;
      gt_q          <= 1'b0;
      match_count_q <= '0;
      run_q         <= '0;
      prev_mode_q   <= MODE_EQ;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      result_q      <= result_d;
      eq_q          <= eq_d;
      lt_q          <= lt_d;
      gt_q          <= gt_d;
      match_count_q <= match_count_d;
      run_q         <= run_d;
      prev_mode_q   <= prev_mode_d;
    end
  end

  assign bus_io.out_valid   = out_valid_q;
  assign bus_io.result      = result_q;
  assign bus_io.eq          = eq_q;
  assign bus_io.lt          = lt_q;
  assign bus_io.gt          = gt_q;
  assign bus_io.match_count = match_count_q;
  assign bus_io.locked      = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_comparador_palavras_sequencial.sv
// Directed bench: two comparators (CNT_WIDTH 8 and 2) share one stimulus stream.
module tb_comparador_palavras_sequencial;
  localparam logic [1:0] EQ = 2'b00, NE = 2'b01, LT = 2'b10, GT = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [2:0] a, b;
  logic [1:0] mode;
  logic       out_ready;

  int tests = 0;
  int fails = 0;

  comparador_palavras_sequencial_if #(.WIDTH(3), .CNT_WIDTH(8)) if0 ();
  comparador_palavras_sequencial_if #(.WIDTH(3), .CNT_WIDTH(2)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.a         = a;
  assign if0.b         = b;
  assign if0.mode      = mode;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.a         = a;
  assign if1.b         = b;
  assign if1.mode      = mode;
  assign if1.out_ready = out_ready;

  comparador_palavras_sequencial #(.WIDTH(3), .CNT_WIDTH(8), .LOCK_COUNT(4)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .bus_io  (if0.slave)
  );

  comparador_palavras_sequencial #(.WIDTH(3), .CNT_WIDTH(2), .LOCK_COUNT(4)) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .bus_io  (if1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] ta, input logic [2:0] tb_v, input logic [1:0] tm);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    mode     = tm;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; mode = EQ; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", if0.out_valid, 0);
    check("rst_result", if0.result, 0);
    check("rst_eqltgt", {if0.eq, if0.lt, if0.gt}, 0);
    check("rst_count", if0.match_count, 0);
    check("rst_locked", if0.locked, 0);
    #10 rst_n = 1'b1;
    cyc();
    check("rst_in_ready", if0.in_ready, 1);

    // Four EQ matches: count 1..4, lock on the 4th
    for (int i = 1; i <= 4; i++) begin
      send(3'd5, 3'd5, EQ);
      check("stream_result", if0.result, 1);
      check("stream_count", if0.match_count, i);
      check("stream_locked", if0.locked, (i == 4));
      check("stream_count_sat2", if1.match_count, (i > 3) ? 3 : i);
    end

    // Lock break: mismatch drops lock, count unchanged
    send(3'd1, 3'd0, EQ);
    check("break_result", if0.result, 0);
    check("break_rel", {if0.eq, if0.lt, if0.gt}, 3'b001);
    check("break_locked", if0.locked, 0);
    check("break_count", if0.match_count, 4);

    // Mode sweep a=2 b=6
    send(3'd2, 3'd6, EQ);
    check("sweep_eq_result", if0.result, 0);
    check("sweep_rel", {if0.eq, if0.lt, if0.gt}, 3'b010);
    send(3'd2, 3'd6, NE);
    check("sweep_ne_result", if0.result, 1);
    send(3'd2, 3'd6, LT);
    check("sweep_lt_result", if0.result, 1);
    send(3'd2, 3'd6, GT);
    check("sweep_gt_result", if0.result, 0);
    check("sweep_count", if0.match_count, 6);

    // Three EQ matches then NE match: run restarts, no lock
    for (int i = 0; i < 3; i++) send(3'd5, 3'd5, EQ);
    check("run3_locked", if0.locked, 0);
    send(3'd1, 3'd2, NE);
    check("modechg_result", if0.result, 1);
    check("modechg_locked", if0.locked, 0);
    check("modechg_count", if0.match_count, 10);
    send(3'd1, 3'd2, NE);
    send(3'd1, 3'd2, NE);
    check("ne_run3_locked", if0.locked, 0);
    send(3'd1, 3'd2, NE);
    check("ne_run4_locked", if0.locked, 1);
    check("ne_run4_count", if0.match_count, 13);

    // Backpressure
    send(3'd7, 3'd7, EQ);
    check("bp_first_result", if0.result, 1);
    check("bp_first_count", if0.match_count, 14);
    check("bp_first_locked", if0.locked, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 3'd3; b = 3'd4; mode = LT;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("bp_in_ready", if0.in_ready, 0);
      check("bp_out_valid", if0.out_valid, 1);
      check("bp_result", if0.result, 1);
      check("bp_eq", if0.eq, 1);
      check("bp_count", if0.match_count, 14);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", if0.in_ready, 1);
    cyc();
    in_valid = 1'b0;
    check("b2b_out_valid", if0.out_valid, 1);
    check("b2b_rel", {if0.eq, if0.lt, if0.gt}, 3'b010);
    check("b2b_result", if0.result, 1);
    check("b2b_count", if0.match_count, 15);
    cyc();
    check("b2b_drain_valid", if0.out_valid, 0);
    check("b2b_no_dup_count", if0.match_count, 15);

    // Clear alone, then saturation on the 2-bit counter
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clear_count", if0.match_count, 0);
    check("clear_count2", if1.match_count, 0);
    check("clear_locked", if0.locked, 0);
    for (int i = 1; i <= 5; i++) begin
      send(3'd4, 3'd4, EQ);
      check("sat_count2", if1.match_count, (i > 3) ? 3 : i);
      check("sat_count8", if0.match_count, i);
    end
    check("sat_locked", if0.locked, 1);

    // Clear with a simultaneous matching accept
    clear = 1'b1;
    send(3'd6, 3'd6, EQ);
    clear = 1'b0;
    check("clracc_result", if0.result, 1);
    check("clracc_valid", if0.out_valid, 1);
    check("clracc_count8", if0.match_count, 0);
    check("clracc_count2", if1.match_count, 0);
    check("clracc_locked", if0.locked, 0);
    send(3'd6, 3'd6, EQ);
    check("post_clear_count", if0.match_count, 1);
    check("post_clear_locked", if0.locked, 0);

    // Asynchronous reset mid-stream with out_valid=1
    in_valid = 1'b1; a = 3'd2; b = 3'd2; mode = EQ;
    cyc();
    check("pre_rst_valid", if0.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", if0.out_valid, 0);
    check("arst_result", if0.result, 0);
    check("arst_eqltgt", {if0.eq, if0.lt, if0.gt}, 0);
    check("arst_count", if0.match_count, 0);
    check("arst_locked", if0.locked, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
    check("arst_in_ready", if0.in_ready, 1);
    check("arst_idle_valid", if0.out_valid, 0);
    send(3'd3, 3'd3, EQ);
    check("arst_first_count", if0.match_count, 1);
    check("arst_first_result", if0.result, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/comparador_palavras_sequencial.md
# comparador_palavras_sequencial

Parametrised, registered word comparator with valid/ready handshake, selectable comparison mode, a saturating match counter and a consecutive-match lock detector. It generalises the fixed 3-bit combinational equality comparator to WIDTH-bit unsigned operands and adds NE/LT/GT modes. It also adds match statistics for the surrounding datapath and sits between an operand source and a result consumer on a single clock domain.

## Interface
- WIDTH, 3: operand width in bits, ≥1.
- CNT_WIDTH, 8: width of match_count, ≥1.
- LOCK_COUNT, 4: consecutive matches required to assert locked, ≥1.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of match_count, run counter and lock FSM.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block can accept a transaction.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- mode  input  2  00 EQ (a==b), 01 NE (a!=b), 10 LT (a<b), 11 GT (a>b); sampled with the transaction.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  consumer accepts the result.
- result  output  1  selected comparison outcome.
- eq, lt, gt  output  1 each  raw relations of the accepted operands (exactly one set when out_valid=1).
- match_count  output  CNT_WIDTH  number of accepted transactions with result=1, saturating.
- locked  output  1  high in LOCKED state.

## Operation
- Accept: in_valid && in_ready at rising edge. in_ready = !out_valid || out_ready (combinational; one-deep output register, full throughput).
- On accept: eq/lt/gt/result registered from a, b, mode; out_valid set. Without an accept, out_valid clears when out_ready=1; otherwise all result outputs hold.
- Statistics update only on accept, from the new result:
  - match_count += 1 when result=1, saturating at 2^CNT_WIDTH-1 with no wrap.
  - Run counter (width $clog2(LOCK_COUNT+1)): result=1 → run+1, saturating at LOCK_COUNT. result=0 → 0. If the mode differs from the previously accepted mode, the run restarts: run = result ? 1 : 0.
- Lock FSM:
  - IDLE: run=0.
  - TRACK: 0<run<LOCK_COUNT.
  - LOCKED: run=LOCK_COUNT.
  - Transitions follow the run value after each accept. Any result=0 or clear → IDLE. With LOCK_COUNT=1, the first match goes IDLE→LOCKED directly.
  - locked = (state==LOCKED), registered.
- Stored previous mode resets to 00. The first transaction after reset or clear is never treated as a mode change.
- clear priority: clear has priority over a simultaneous accept for statistics. match_count=0, run=0, state IDLE, previous mode=00; the accepted transaction still produces its output but is not counted.
- Reset (rst_n low, asynchronous):
  - Output values: out_valid=0, result=0, eq=0, lt=0, gt=0, match_count=0, locked=0.
  - Internal state: run=0, state IDLE, previous mode=00.
  - in_ready=1 from the first cycle after release.
  - Reset mid-transaction discards any pending result.

## Timing
- Latency 1 cycle: a transaction accepted at edge N shows result/eq/lt/gt/out_valid after edge N.
- match_count and locked update at that same edge N, so they are coherent with the result presented.
- Throughput: 1 transaction/cycle while out_ready=1.
- Backpressure: out_valid=1 && out_ready=0 → in_ready=0 and all outputs stable until the cycle out_ready=1. In that cycle a new accept may occur, giving back-to-back transfer.
- clear takes effect at the edge it is sampled and is visible in the following cycle.
- No combinational path from a/b/mode to any output. The only combinational path is out_ready→in_ready.

## Test plan
- WIDTH=3, out_ready=1, mode=EQ: stream a=b=5 for four cycles → result=1 each cycle one cycle later; match_count 1,2,3,4; locked rises together with the 4th result.
- Mode sweep with a=2, b=6: EQ→result 0, eq=0 lt=1 gt=0; NE→1; LT→1; GT→0. Each value is checked one cycle after accept.
- Backpressure: accept a=7,b=7, hold out_ready=0 for 3 cycles → in_ready=0, result=1 and out_valid=1 stable. Assert out_ready=1 with a new transaction pending → back-to-back accept, no loss or duplication.
- Lock break and mode change:
  - After locked=1 (EQ), send a=1,b=0 → locked=0 and match_count unchanged.
  - Send 3 matches in EQ, then a match in NE → run restarts at 1 and locked stays 0.
- Saturation and clear with CNT_WIDTH=2:
  - Five matches → match_count stays at 3.
  - clear together with a matching accept → result=1 presented, match_count=0, locked=0.
- Asynchronous reset: assert rst_n=0 mid-stream with out_valid=1 → all outputs 0 immediately, no clock needed. After release, in_ready=1 and the first match gives match_count=1.
